// File: rtl/rv_pkg.sv
// Shared RV32I integer-pipeline definitions: register-file widths, load funct3
// codes, the writeback entry layout and the load-data formatter (also used by
// the data-memory unit).
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One pending register write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

    // Extract and extend load data from the aligned memory word.
    // Unknown encodings are treated as a full-word load.
    function automatic logic [XLEN-1:0] load_format(
        input logic [2:0]      funct3,
        input logic [1:0]      byte_off,
        input logic [XLEN-1:0] rdata
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = rdata[{byte_off, 3'b000} +: 8];
        h = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LBU:  r = {24'd0, b};
            F3_LHU:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-response buffer for the writeback unit: synchronous FIFO of formatted
// {rd, data} entries with count/full/empty status. The caller never pops
// when empty nor pushes when full.
module wb_load_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU results and formatted load responses onto
// the register file's single write port. Loads that lose arbitration are
// buffered and retire in acceptance order.
// Optional macro WB_STARVE_GUARD_EN: a buffered load that has waited
// STARVE_LIMIT cycles pre-empts the ALU for one cycle (alu_ready drops).
module writeback_unit
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_byte_off,
    input  logic [XLEN-1:0]       ld_rdata,
    output logic                  wb_enable,
    output logic [REG_ADDR_W-1:0] rs_d,
    output logic [XLEN-1:0]       reg_d,
    output logic                  wb_pending
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t        ld_entry;
    wb_entry_t        head;
    wb_entry_t        sel;
    wb_src_e          src;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             ld_acc;
    logic             push;
    logic             pop;
    logic             guard_fire;

    // Format at acceptance so the buffer holds final register values.
    assign ld_entry = '{rd: ld_rd, data: load_format(ld_funct3, ld_byte_off, ld_rdata)};

    // Ready/pending come from registered state only; a same-cycle pop does
    // not reopen a full buffer.
    assign ld_ready   = ~full;
    assign wb_pending = (count != '0);
    assign ld_acc     = ld_valid & ld_ready;
    assign alu_ready  = ~guard_fire;

`ifdef WB_STARVE_GUARD_EN
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);

    logic [ST_W-1:0] starve_cnt;

    assign guard_fire = ~empty & (starve_cnt == ST_W'(STARVE_LIMIT));

    // Age of the buffer head in cycles lost; the guard pops when it hits the
    // limit, so the counter never runs past STARVE_LIMIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)            starve_cnt <= '0;
        else if (empty || pop) starve_cnt <= '0;
        else                   starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign guard_fire = 1'b0;
`endif

    // Source priority: starve guard, ALU, buffer head, bypassed load.
    always_comb begin
        src  = SRC_NONE;
        sel  = '0;
        pop  = 1'b0;
        if (guard_fire)     src = SRC_FIFO;
        else if (alu_valid) src = SRC_ALU;
        else if (!empty)    src = SRC_FIFO;
        else if (ld_acc)    src = SRC_BYPASS;
        case (src)
            SRC_ALU:    sel = '{rd: alu_rd, data: alu_data};
            SRC_FIFO: begin
                sel = head;
                pop = 1'b1;
            end
            SRC_BYPASS: sel = ld_entry;
            default:    sel = '0;
        endcase
        push = ld_acc & (src != SRC_BYPASS);
    end

    wb_load_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (ld_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Registered write port; x0 results are consumed but not strobed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_enable <= 1'b0;
            rs_d      <= '0;
            reg_d     <= '0;
        end else begin
            wb_enable <= (src != SRC_NONE) && (sel.rd != '0);
            if (src != SRC_NONE) begin
                rs_d  <= sel.rd;
                reg_d <= sel.data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a queue-based reference model predicts
// each register write and its cycle; a separate monitor compares every cycle.
module tb_writeback_unit;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic        alu_ready, ld_ready, wb_enable, wb_pending;
    logic [4:0]  alu_rd = '0, ld_rd = '0, rs_d;
    logic [31:0] alu_data = '0, ld_rdata = '0, reg_d;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_byte_off = '0;

    always #5 clock = ~clock;

    writeback_unit #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .ld_byte_off(ld_byte_off), .ld_rdata(ld_rdata),
        .wb_enable(wb_enable), .rs_d(rs_d), .reg_d(reg_d), .wb_pending(wb_pending)
    );

    typedef struct { int unsigned cyc; logic [4:0] rd; logic [31:0] data; } exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } ld_t;

    exp_t        exp_q[$];
    ld_t         bq[$];
    int          m_st = 0;
    int unsigned cyc = 0;
    int          n_checks = 0, n_fail = 0;
    bit          mon_on = 1'b0;
    bit          a_acc, l_acc;

    // pending driver transactions (held until accepted)
    bit          ap = 0, lp = 0;
    logic [4:0]  p_ard, p_lrd;
    logic [31:0] p_ad, p_ldata;
    logic [2:0]  p_f3;
    logic [1:0]  p_off;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load formatting from the ISA definition, using shifts and masks.
    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Drive one cycle, check ready/pending, and advance the reference model.
    task automatic tick(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] rdata);
        bit   fire, wr, popped, bypass;
        int   had;
        ld_t  ld, hd;
        exp_t e;
        @(negedge clock);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_byte_off = off; ld_rdata = rdata;
        had  = bq.size();
        fire = GUARD && had > 0 && m_st == LIMIT;
        chk("alu_ready", alu_ready, !fire);
        chk("ld_ready", ld_ready, had < DEPTH);
        chk("wb_pending", wb_pending, had != 0);
        l_acc = lv && had < DEPTH;
        a_acc = av && !fire;
        ld = '{lrd, ref_fmt(f3, off, rdata)};
        wr = 1; popped = 0; bypass = 0;
        if (fire || (!av && had > 0)) begin
            hd = bq.pop_front(); popped = 1;
            e = '{cyc + 1, hd.rd, hd.data};
        end else if (av) begin
            e = '{cyc + 1, ard, ad};
        end else if (l_acc) begin
            bypass = 1;
            e = '{cyc + 1, ld.rd, ld.data};
        end else begin
            wr = 0;
        end
        if (wr) exp_q.push_back(e);
        if (l_acc && !bypass) bq.push_back(ld);
        m_st = (had == 0 || popped) ? 0 : m_st + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Randomized traffic; apct/lpct are offer probabilities, lmax caps new loads.
    task automatic run(input int n, input int apct, input int lpct, input int lmax);
        int issued = 0;
        for (int i = 0; i < n; i++) begin
            if (!ap && $urandom_range(99) < apct) begin
                ap = 1; p_ard = 5'($urandom); p_ad = $urandom;
            end
            if (!lp && (lmax < 0 || issued < lmax) && $urandom_range(99) < lpct) begin
                lp = 1; issued++;
                p_lrd = 5'($urandom); p_f3 = 3'($urandom); p_off = 2'($urandom);
                p_ldata = $urandom;
            end
            tick(ap, p_ard, p_ad, lp, p_lrd, p_f3, p_off, p_ldata);
            if (a_acc) ap = 0;
            if (l_acc) lp = 0;
        end
    endtask

    // Monitor: pops the scoreboard when a write is due, else expects no strobe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (mon_on && reset) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    chk("wb_enable", wb_enable, e.rd != 0);
                    chk("rs_d", rs_d, e.rd);
                    chk("reg_d", reg_d, e.data);
                end else begin
                    chk("idle_wb_enable", wb_enable, 0);
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_wb_enable", wb_enable, 0);
        chk("rst_rs_d", rs_d, 0);
        chk("rst_reg_d", reg_d, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_wb_pending", wb_pending, 0);
        @(negedge clock);
        reset = 1'b1;
        mon_on = 1'b1;

        // LB bypass: byte 2 of 0x12803456 is 0x80
        tick(0, 0, 0, 1, 5, 3'b000, 2, 32'h1280_3456);
        @(posedge clock); #1;
        chk("lb_wb_enable", wb_enable, 1);
        chk("lb_rs_d", rs_d, 5);
        chk("lb_reg_d", reg_d, 32'hFFFF_FF80);
        idle(1);

        // ALU and LHU in the same cycle: ALU first, load one cycle later
        tick(1, 3, 32'h11, 1, 4, 3'b101, 2, 32'hBEEF_0000);
        @(posedge clock); #1;
        chk("co_rs_d_alu", rs_d, 3);
        chk("co_reg_d_alu", reg_d, 32'h11);
        chk("co_pending", wb_pending, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        chk("co_rs_d_ld", rs_d, 4);
        chk("co_reg_d_ld", reg_d, 32'h0000_BEEF);
        chk("co_pending_clr", wb_pending, 0);

        // x0 destination: consumed, not strobed
        tick(1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        chk("x0_wb_enable", wb_enable, 0);
        chk("x0_reg_d", reg_d, 32'hDEAD);
        idle(1);

        // continuous ALU with three loads, then drain
        run(12, 100, 100, 3);
        run(20, 0, 0, 0);

        // random traffic, heavy then light ALU load
        run(600, 90, 60, -1);
        run(600, 40, 50, -1);
        run(30, 0, 0, 0);

        // two loads buffered behind ALU, then asynchronous reset mid-cycle
        tick(1, 7, 32'h77, 1, 8, 3'b010, 0, 32'hAAAA_5555);
        tick(1, 9, 32'h99, 1, 10, 3'b010, 0, 32'h1234);
        @(posedge clock); #3;
        reset = 1'b0;
        alu_valid = 0; ld_valid = 0;
        #1;
        chk("arst_wb_enable", wb_enable, 0);
        chk("arst_rs_d", rs_d, 0);
        chk("arst_reg_d", reg_d, 0);
        chk("arst_ld_ready", ld_ready, 1);
        chk("arst_alu_ready", alu_ready, 1);
        chk("arst_pending", wb_pending, 0);
        bq.delete(); exp_q.delete(); m_st = 0; ap = 0; lp = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle(4);

        run(300, 60, 50, -1);
        run(40, 0, 0, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
